// File: rtl/draw_sprites_pkg.sv
// Shared types for the sprite compositor: VGA bus layout and field macros.
// Build option: SPRITE_MIRROR_EN adds per-channel horizontal flip.
`ifndef VGA_MACROS_DEFINED
`define VGA_MACROS_DEFINED
`define VGA_BUS_SIZE 40
`define VGA_RGB_BITS 11:0
`define VGA_HBLNK_BITS 12
`define VGA_HS_BITS 13
`define VGA_HCOUNT_BITS 25:14
`define VGA_VBLNK_BITS 26
`define VGA_VS_BITS 27
`define VGA_VCOUNT_BITS 39:28
`define SPR_COORD_W 12
`define VGA_RGB_W 12
`endif

package draw_sprites_pkg;

    localparam int SPR_COORD_W = `SPR_COORD_W;
    localparam int RGB_W = `VGA_RGB_W;

    // Field order matches the bit ranges of the bus macros above.
    typedef struct packed {
        logic [11:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam int VGA_BUS_SIZE = $bits(vga_t);

endpackage

// File: rtl/draw_sprites_if.sv
// VGA bus bundle; master drives the bus, slave consumes it.
interface draw_sprites_if;
    import draw_sprites_pkg::*;

    vga_t bus;

    modport master (output bus);
    modport slave (input bus);

endinterface

// File: rtl/draw_sprites_sprite_channel.sv
// One sprite channel: frame-latched shadow position, hit test, ROM address
// and the hit delay that lines up with the ROM data. Mirror: SPRITE_MIRROR_EN.
module sprite_channel
    import draw_sprites_pkg::*;
#(
    parameter int SPR_W  = 64,
    parameter int SPR_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              latch,
    input  logic              blank,
    input  logic [11:0]       hcount,
    input  logic [11:0]       vcount,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic              en,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror,
`endif
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    logic [11:0]       x_s;
    logic [11:0]       y_s;
    logic              en_s;
    logic              hit_q;
    logic              hit_now;
    logic [12:0]       x_lo;
    logic [12:0]       x_hi;
    logic [12:0]       y_lo;
    logic [12:0]       y_hi;
    logic [11:0]       dx;
    logic [11:0]       dy;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_next;

`ifdef SPRITE_MIRROR_EN
    logic              mir_s;
`endif

    // 13-bit bounds so a sprite near 4095 clips instead of wrapping to 0.
    assign x_lo = {1'b0, x_s};
    assign y_lo = {1'b0, y_s};
    assign x_hi = x_lo + 13'(SPR_W - 1);
    assign y_hi = y_lo + 13'(SPR_H - 1);

    assign hit_now = en_s && !blank
        && ({1'b0, hcount} >= x_lo) && ({1'b0, hcount} <= x_hi)
        && ({1'b0, vcount} >= y_lo) && ({1'b0, vcount} <= y_hi);

    assign dx = hcount - x_s;
    assign dy = vcount - y_s;

`ifdef SPRITE_MIRROR_EN
    assign col = mir_s ? ADDR_W'(SPR_W - 1) - ADDR_W'(dx)
                       : ADDR_W'(dx);
`else
    assign col = ADDR_W'(dx);
`endif

    assign addr_next = ADDR_W'(dy) * ADDR_W'(SPR_W) + col;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_s   <= '0;
            y_s   <= '0;
            en_s  <= 1'b0;
            hit_q <= 1'b0;
            hit   <= 1'b0;
            addr  <= '0;
`ifdef SPRITE_MIRROR_EN
            mir_s <= 1'b0;
`endif
        end else begin
            if (latch) begin
                x_s  <= xpos;
                y_s  <= ypos;
                en_s <= en;
`ifdef SPRITE_MIRROR_EN
                mir_s <= mirror;
`endif
            end
            hit_q <= hit_now;
            hit   <= hit_q;
            if (hit_now) begin
                addr <= addr_next;
            end
        end
    end

endmodule

// File: rtl/draw_sprites.sv
// Sprite compositor: NUM_SPRITES channels over the background bus, 3-cycle
// latency, lowest index wins. Optional SPRITE_MIRROR_EN adds the mirror port.
module draw_sprites
    import draw_sprites_pkg::*;
#(
    parameter int          NUM_SPRITES = 2,
    parameter int          SPR_W       = 64,
    parameter int          SPR_H       = 64,
    parameter int          ADDR_W      = 12,
    parameter logic [11:0] TRANSP_KEY  = 12'h000
) (
    input  logic                          pclk,
    input  logic                          rst,
    input  logic [12*NUM_SPRITES-1:0]     xpos,
    input  logic [12*NUM_SPRITES-1:0]     ypos,
    input  logic [NUM_SPRITES-1:0]        sprite_en,
`ifdef SPRITE_MIRROR_EN
    input  logic [NUM_SPRITES-1:0]        mirror,
`endif
    draw_sprites_if.slave                 vga_in,
    draw_sprites_if.master                vga_out,
    output logic [ADDR_W*NUM_SPRITES-1:0] pixel_addr,
    input  logic [12*NUM_SPRITES-1:0]     rgb_pixel
);

    vga_t                   bus_d1;
    vga_t                   bus_d2;
    vga_t                   mix;
    logic                   vblnk_q;
    logic                   latch;
    logic                   blank;
    logic [NUM_SPRITES-1:0] hit;

    assign latch = vga_in.bus.vblnk && !vblnk_q;
    assign blank = vga_in.bus.hblnk || vga_in.bus.vblnk;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
        sprite_channel #(
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .ADDR_W(ADDR_W)
        ) u_ch (
            .clk   (pclk),
            .rst   (rst),
            .latch (latch),
            .blank (blank),
            .hcount(vga_in.bus.hcount),
            .vcount(vga_in.bus.vcount),
            .xpos  (xpos[12*g +: 12]),
            .ypos  (ypos[12*g +: 12]),
            .en    (sprite_en[g]),
`ifdef SPRITE_MIRROR_EN
            .mirror(mirror[g]),
`endif
            .hit   (hit[g]),
            .addr  (pixel_addr[ADDR_W*g +: ADDR_W])
        );
    end

    // Walk from the highest index down so the lowest opaque channel lands last.
    always_comb begin
        mix = bus_d2;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit[i] && rgb_pixel[12*i +: 12] != TRANSP_KEY) begin
                mix.rgb = rgb_pixel[12*i +: 12];
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_q     <= 1'b0;
            bus_d1      <= '0;
            bus_d2      <= '0;
            vga_out.bus <= '0;
        end else begin
            vblnk_q     <= vga_in.bus.vblnk;
            bus_d1      <= vga_in.bus;
            bus_d2      <= bus_d1;
            vga_out.bus <= mix;
        end
    end

endmodule

// File: tb/tb_draw_sprites.sv
// Bench for draw_sprites: table vectors, hand sequences and a random run
// against a pixel-level reference model. Honours SPRITE_MIRROR_EN.
module tb_draw_sprites;
    import draw_sprites_pkg::*;

    localparam int N = 2;
    localparam int W = 4;
    localparam int H = 4;
    localparam int AW = 4;
    localparam logic [11:0] KEY = 12'h000;
    localparam logic [11:0] BG = 12'h5A5;

    logic          pclk = 1'b0;
    logic          rst;
    logic [23:0]   xpos;
    logic [23:0]   ypos;
    logic [1:0]    sprite_en;
    logic [1:0]    mirror;
    logic [7:0]    pixel_addr;
    logic [23:0]   rgb_pixel;

    draw_sprites_if vin ();
    draw_sprites_if vout ();

    draw_sprites #(
        .NUM_SPRITES(N),
        .SPR_W      (W),
        .SPR_H      (H),
        .ADDR_W     (AW),
        .TRANSP_KEY (KEY)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .xpos      (xpos),
        .ypos      (ypos),
        .sprite_en (sprite_en),
`ifdef SPRITE_MIRROR_EN
        .mirror    (mirror),
`endif
        .vga_in    (vin),
        .vga_out   (vout),
        .pixel_addr(pixel_addr),
        .rgb_pixel (rgb_pixel)
    );

    always #5 pclk = ~pclk;

    logic [11:0] rom_tab [N][16];

    always @(posedge pclk) begin
        for (int i = 0; i < N; i++) begin
            rgb_pixel[12*i +: 12] <= rom_tab[i][pixel_addr[AW*i +: AW]];
        end
    end

    int checks = 0;
    int errors = 0;

    logic [23:0] nx, ny;
    logic [1:0]  nen, nmir;

    int          m_x [N];
    int          m_y [N];
    bit          m_en [N];
    bit          m_mir [N];
    bit          m_prev;
    logic [3:0]  m_addr [N];
    vga_t        exp_q [$];
    bit          addr_valid;
    logic [7:0]  exp_addr;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
            m_en[i] = 0;
            m_mir[i] = 0;
            m_addr[i] = '0;
        end
        m_prev = 0;
        exp_q.delete();
        addr_valid = 0;
        exp_addr = '0;
    endtask

    // Reference: rectangle membership, row-major address, first opaque wins.
    task automatic model_push(input vga_t v);
        vga_t e;
        bit   done;
        int   hc, vc, col, a;
        e = v;
        done = 0;
        hc = int'(v.hcount);
        vc = int'(v.vcount);
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && !v.hblnk && !v.vblnk
                && hc >= m_x[i] && hc < m_x[i] + W
                && vc >= m_y[i] && vc < m_y[i] + H) begin
                col = hc - m_x[i];
                if (m_mir[i]) col = W - 1 - col;
                a = (vc - m_y[i]) * W + col;
                m_addr[i] = 4'(a);
                if (!done && rom_tab[i][a] != KEY) begin
                    e.rgb = rom_tab[i][a];
                    done = 1;
                end
            end
        end
        exp_q.push_back(e);
        if (v.vblnk && !m_prev) begin
            for (int i = 0; i < N; i++) begin
                m_x[i] = int'(xpos[12*i +: 12]);
                m_y[i] = int'(ypos[12*i +: 12]);
                m_en[i] = sprite_en[i];
`ifdef SPRITE_MIRROR_EN
                m_mir[i] = mirror[i];
`else
                m_mir[i] = 0;
`endif
            end
        end
        m_prev = v.vblnk;
        exp_addr = {m_addr[1], m_addr[0]};
        addr_valid = 1;
    endtask

    task automatic step(input vga_t v);
        vga_t e;
        @(posedge pclk);
        #1;
        if (addr_valid) chk("pixel_addr", 64'(pixel_addr), 64'(exp_addr));
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk("vga_out", 64'(vout.bus), 64'(e));
        end
        xpos = nx;
        ypos = ny;
        sprite_en = nen;
        mirror = nmir;
        vin.bus = v;
        model_push(v);
    endtask

    function automatic vga_t idle();
        vga_t v;
        v = '0;
        v.hblnk = 1'b1;
        v.rgb = BG;
        return v;
    endfunction

    function automatic vga_t vbl();
        vga_t v;
        v = idle();
        v.vblnk = 1'b1;
        return v;
    endfunction

    function automatic vga_t pix(int hc, int vc);
        vga_t v;
        v = '0;
        v.hcount = 12'(hc);
        v.vcount = 12'(vc);
        v.rgb = BG;
        return v;
    endfunction

    task automatic latch_frame();
        step(idle());
        step(vbl());
        step(vbl());
        step(idle());
    endtask

    task automatic pix_check(string nm, int hc, int vc, logic [11:0] r);
        step(pix(hc, vc));
        repeat (3) step(idle());
        chk(nm, 64'(vout.bus.rgb), 64'(r));
    endtask

    task automatic rom_default();
        for (int a = 0; a < 16; a++) begin
            rom_tab[0][a] = (a == 0) ? KEY : 12'(a + 1);
            rom_tab[1][a] = 12'(12'h100 + a);
        end
    endtask

    typedef struct {
        int          hc, vc, x0, y0, x1, y1;
        logic [1:0]  en;
        logic [11:0] rgb;
        int          addr0;
    } vec_t;

    vec_t tab [14];

    initial begin
        vga_t v;
        bit   edge_mode;

        tab[0]  = '{101, 52, 100, 50, 0, 0, 2'b01, 12'h00A, 9};
        tab[1]  = '{99, 52, 100, 50, 0, 0, 2'b01, BG, -1};
        tab[2]  = '{103, 53, 100, 50, 0, 0, 2'b01, 12'h010, 15};
        tab[3]  = '{104, 53, 100, 50, 0, 0, 2'b01, BG, -1};
        tab[4]  = '{102, 51, 102, 50, 100, 50, 2'b11, 12'h005, 4};
        tab[5]  = '{103, 51, 102, 50, 100, 50, 2'b11, 12'h006, 5};
        tab[6]  = '{101, 51, 102, 50, 100, 50, 2'b11, 12'h105, 5};
        tab[7]  = '{100, 50, 102, 50, 100, 50, 2'b11, 12'h100, 5};
        tab[8]  = '{100, 50, 100, 50, 100, 50, 2'b11, 12'h100, 0};
        tab[9]  = '{100, 50, 100, 50, 100, 50, 2'b01, BG, 0};
        tab[10] = '{4095, 10, 4094, 10, 0, 0, 2'b01, 12'h002, 1};
        tab[11] = '{0, 10, 4094, 10, 0, 0, 2'b01, BG, 1};
        tab[12] = '{4094, 13, 4094, 10, 0, 0, 2'b01, 12'h00D, 12};
        tab[13] = '{101, 52, 100, 50, 0, 0, 2'b00, BG, -1};

        rom_default();
        nx = '0; ny = '0; nen = '0; nmir = '0;
        xpos = '0; ypos = '0; sprite_en = '0; mirror = '0;
        vin.bus = idle();
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset_vga_out", 64'(vout.bus), 64'd0);
        chk("reset_addr", 64'(pixel_addr), 64'd0);
        rst = 1'b0;

        foreach (tab[k]) begin
            nx = {12'(tab[k].x1), 12'(tab[k].x0)};
            ny = {12'(tab[k].y1), 12'(tab[k].y0)};
            nen = tab[k].en;
            latch_frame();
            step(pix(tab[k].hc, tab[k].vc));
            step(idle());
            if (tab[k].addr0 >= 0)
                chk($sformatf("tab%0d_addr", k),
                    64'(pixel_addr[3:0]), 64'(tab[k].addr0));
            step(idle());
            step(idle());
            chk($sformatf("tab%0d_rgb", k),
                64'(vout.bus.rgb), 64'(tab[k].rgb));
        end

        // Position change mid-frame only takes effect after vblnk rises.
        nx = {12'd0, 12'd100};
        ny = {12'd0, 12'd50};
        nen = 2'b01;
        latch_frame();
        pix_check("frame_old_pos", 101, 52, 12'h00A);
        step(pix(5, 300));
        nx = {12'd0, 12'd200};
        step(pix(6, 300));
        pix_check("mid_frame_hold", 101, 52, 12'h00A);
        pix_check("mid_frame_new_miss", 201, 52, BG);
        latch_frame();
        pix_check("next_frame_new", 201, 52, 12'h00A);
        pix_check("next_frame_old", 101, 52, BG);

        // Asynchronous reset mid-line clears output and shadow enables.
        nx = {12'd0, 12'd100};
        latch_frame();
        step(pix(101, 52));
        step(pix(102, 52));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_vga_out", 64'(vout.bus), 64'd0);
        chk("rst_addr", 64'(pixel_addr), 64'd0);
        model_reset();
        @(posedge pclk);
        #1;
        rst = 1'b0;
        vin.bus = idle();
        pix_check("rst_no_draw", 101, 52, BG);
        latch_frame();
        pix_check("rst_redraw", 101, 52, 12'h00A);

`ifdef SPRITE_MIRROR_EN
        nx = '0;
        ny = '0;
        nen = 2'b01;
        nmir = 2'b01;
        latch_frame();
        step(pix(0, 0));
        step(idle());
        chk("mirror_addr", 64'(pixel_addr[3:0]), 64'd3);
        repeat (2) step(idle());
        nmir = '0;
`endif

        for (int f = 0; f < 20; f++) begin
            for (int a = 0; a < 16; a++) begin
                for (int i = 0; i < N; i++) begin
                    rom_tab[i][a] = ($urandom_range(0, 3) == 0)
                        ? KEY : 12'($urandom);
                end
            end
            edge_mode = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                nx[12*i +: 12] = edge_mode
                    ? 12'($urandom_range(4088, 4095))
                    : 12'($urandom_range(0, 20));
                ny[12*i +: 12] = 12'($urandom_range(0, 20));
            end
            nen = 2'($urandom);
`ifdef SPRITE_MIRROR_EN
            nmir = 2'($urandom);
`endif
            latch_frame();
            for (int c = 0; c < 150; c++) begin
                v = '0;
                if (edge_mode && $urandom_range(0, 1) == 1)
                    v.hcount = ($urandom_range(0, 1) == 1)
                        ? 12'($urandom_range(4088, 4095))
                        : 12'($urandom_range(0, 5));
                else
                    v.hcount = 12'($urandom_range(0, 24));
                v.vcount = 12'($urandom_range(0, 24));
                v.hblnk = ($urandom_range(0, 7) == 0);
                v.vblnk = ($urandom_range(0, 39) == 0);
                v.hsync = 1'($urandom);
                v.vsync = 1'($urandom);
                v.rgb = 12'($urandom);
                if ($urandom_range(0, 19) == 0) begin
                    nx[11:0] = 12'($urandom_range(0, 20));
                    ny[23:12] = 12'($urandom_range(0, 20));
                    nen = 2'($urandom);
                end
                step(v);
            end
            repeat (3) step(idle());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
